// File: rtl/sccb_cfg_ctrl_pkg.sv
// Shared definitions for the OV5640 SCCB configuration controller.
// Holds the FSM state encoding, the default device write address and the
// field widths of the 32-bit reg_data word {dev_addr, reg_addr, reg_val}.
package sccb_cfg_ctrl_pkg;

  localparam int unsigned DevW   = 8;
  localparam int unsigned AddrW  = 16;
  localparam int unsigned ValW   = 8;
  localparam int unsigned RomW   = AddrW + ValW;
  localparam int unsigned DataW  = DevW + RomW;
  localparam int unsigned IdxW   = 10;
  localparam int unsigned CntW   = 16;
  localparam int unsigned RetryW = 2;

  localparam logic [DevW-1:0] DevAddrDefault = 8'h78;

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    LOAD,
    SEND,
    WAIT_ACK,
    GAP,
    DONE,
    ERROR
  } cfg_state_e;

  // Builds the word handed to the bit engine from the device address and a table entry.
  function automatic logic [DataW-1:0] pack_reg_data(input logic [DevW-1:0] dev,
                                                     input logic [RomW-1:0] entry);
    return {dev, entry};
  endfunction

endpackage

// File: rtl/ov5640_cfg_rom.sv
// OV5640 register table: combinational index -> {reg_addr[15:0], reg_val[7:0]}.
// Ports:
//   rom_idx_i  - table index from the controller
//   rom_data_o - table entry for that index
// The listed entries are the bring-up prefix (soft reset, PLL, analog setup).
// Any index past the listed prefix re-issues the "normal operation" write to 0x3008,
// which is idempotent, so REG_NUM can be raised while the table is extended.
module ov5640_cfg_rom
  import sccb_cfg_ctrl_pkg::*;
(
  input  logic [IdxW-1:0] rom_idx_i,
  output logic [RomW-1:0] rom_data_o
);

  always_comb begin
    rom_data_o = 24'h3008_02;
    case (rom_idx_i)
      10'd0:  rom_data_o = 24'h3008_82; // software reset
      10'd1:  rom_data_o = 24'h3008_42; // software power-down during setup
      10'd2:  rom_data_o = 24'h3103_03; // system clock from PLL
      10'd3:  rom_data_o = 24'h3017_ff; // pad output enables
      10'd4:  rom_data_o = 24'h3018_ff;
      10'd5:  rom_data_o = 24'h3034_1a; // PLL control
      10'd6:  rom_data_o = 24'h3035_11;
      10'd7:  rom_data_o = 24'h3036_46;
      10'd8:  rom_data_o = 24'h3037_13;
      10'd9:  rom_data_o = 24'h3108_01;
      10'd10: rom_data_o = 24'h3630_36; // analog tuning
      10'd11: rom_data_o = 24'h3631_0e;
      10'd12: rom_data_o = 24'h3632_e2;
      10'd13: rom_data_o = 24'h3633_12;
      10'd14: rom_data_o = 24'h3621_e0;
      10'd15: rom_data_o = 24'h3704_a0;
      10'd16: rom_data_o = 24'h3703_5a;
      10'd17: rom_data_o = 24'h3715_78;
      10'd18: rom_data_o = 24'h3717_01;
      10'd19: rom_data_o = 24'h370b_60;
      10'd20: rom_data_o = 24'h3705_1a;
      10'd21: rom_data_o = 24'h3905_02;
      10'd22: rom_data_o = 24'h3906_10;
      10'd23: rom_data_o = 24'h3901_0a;
      10'd24: rom_data_o = 24'h3731_12;
      10'd25: rom_data_o = 24'h3600_08;
      10'd26: rom_data_o = 24'h3601_33;
      10'd27: rom_data_o = 24'h302d_60;
      10'd28: rom_data_o = 24'h3620_52;
      10'd29: rom_data_o = 24'h371b_20;
      10'd30: rom_data_o = 24'h471c_50;
      default: rom_data_o = 24'h3008_02;
    endcase
  end

endmodule

// File: rtl/sccb_cfg_ctrl.sv
// SCCB configuration sequencer for the OV5640.
// After cfg_start it waits PWR_DLY cycles, then walks the register table: each entry is
// latched into reg_data, launched with a one-cycle sccb_start, and acknowledged by the bit
// engine's bit_over. A NACK re-sends the same entry up to MAX_RETRY times before giving up.
// Ports:
//   clk_80K, rst_n  - clock, asynchronous active-low reset
//   cfg_start       - level; sampled only in IDLE
//   sccb_start      - one-cycle launch pulse to the bit engine
//   reg_data        - {DEV_ADDR, reg_addr, reg_val}, stable from LOAD until bit_over
//   bit_over,ack_err- end-of-transaction pulse and NACK flag from the engine
//   rom_idx,rom_data- table index out, combinational table entry in
//   cfg_done,cfg_err- terminal status flags
module sccb_cfg_ctrl
  import sccb_cfg_ctrl_pkg::*;
#(
  parameter logic [DevW-1:0]   DEV_ADDR  = DevAddrDefault,
  parameter logic [IdxW-1:0]   REG_NUM   = 10'd250,
  parameter logic [CntW-1:0]   PWR_DLY   = 16'd1600,
  parameter logic [7:0]        GAP_DLY   = 8'd4,
  parameter logic [RetryW-1:0] MAX_RETRY = 2'd3
) (
  input  logic             clk_80K,
  input  logic             rst_n,
  input  logic             cfg_start,
  output logic             sccb_start,
  output logic [DataW-1:0] reg_data,
  input  logic             bit_over,
  input  logic             ack_err,
  output logic [IdxW-1:0]  rom_idx,
  input  logic [RomW-1:0]  rom_data,
  output logic             cfg_done,
  output logic             cfg_err
);

  cfg_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DataW-1:0]  data_q, data_d;
  logic              start_q, start_d;

  always_ff @(posedge clk_80K or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    idx_d   = idx_q;
    data_d  = data_q;
    start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = PWR_WAIT;
          cnt_d   = '0;
        end
      end

      // A zero-length table finishes straight from the power-up wait.
      PWR_WAIT: begin
        if (cnt_q + 16'd1 >= PWR_DLY) begin
          cnt_d   = '0;
          state_d = (idx_q < REG_NUM) ? LOAD : DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // start_d is registered so the pulse lines up with the SEND state.
      LOAD: begin
        data_d  = pack_reg_data(DEV_ADDR, rom_data);
        start_d = 1'b1;
        state_d = SEND;
      end

      SEND: state_d = WAIT_ACK;

      WAIT_ACK: begin
        if (bit_over) begin
          cnt_d = '0;
          if (!ack_err) begin
            retry_d = '0;
            idx_d   = idx_q + 10'd1;
            state_d = GAP;
          end else if (retry_q == MAX_RETRY) begin
            state_d = ERROR;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = GAP;
          end
        end
      end

      // At least one GAP cycle is always spent, even with GAP_DLY of zero.
      GAP: begin
        if (cnt_q + 16'd1 >= {8'd0, GAP_DLY}) begin
          cnt_d   = '0;
          state_d = (idx_q < REG_NUM) ? LOAD : DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign sccb_start = start_q;
  assign reg_data   = data_q;
  assign rom_idx    = idx_q;
  assign cfg_done   = (state_q == DONE);
  assign cfg_err    = (state_q == ERROR);

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Self-checking bench for sccb_cfg_ctrl: a reference model expands each run's ACK/NACK plan
// into the expected sequence of launched table entries; an engine model answers each launch;
// a monitor pops and compares every sccb_start against the expected queue.
module tb_sccb_cfg_ctrl;

  localparam logic [7:0]  DEV  = 8'h78;
  localparam int          NREG = 3;
  localparam int          PWR  = 16;
  localparam int          GAPD = 4;
  localparam int          MAXR = 3;

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        sbo = 1'b0;
  logic        eng_bo = 1'b0;
  logic        eng_ack = 1'b0;
  logic        bit_over;
  logic        ack_err;
  logic        sccb_start;
  logic [31:0] reg_data;
  logic [9:0]  rom_idx;
  logic [23:0] rom_data;
  logic        cfg_done;
  logic        cfg_err;

  logic        s0_start;
  logic [31:0] s0_data;
  logic [9:0]  s0_idx;
  logic        s0_done;
  logic        s0_err;
  logic [23:0] s0_rom = 24'h0;

  logic [9:0]  rom0_idx = 10'd0;
  logic [23:0] rom0_data;

  logic [23:0] rom_tab [0:3];

  exp_t exp_q[$];
  bit   eng_acks[$];
  bit   exp_done, exp_err;
  int   exp_idx, exp_sends;

  int   tot = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_bo = 0;
  int   run_starts = 0;
  bit   first_pending = 1'b0;
  bit   bo_valid = 1'b0;
  bit   lat_fix = 1'b1;

  assign bit_over = eng_bo | sbo;
  assign ack_err  = eng_ack;
  assign rom_data = (rom_idx < 10'd4) ? rom_tab[rom_idx[1:0]] : 24'hffffff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sccb_cfg_ctrl #(
    .DEV_ADDR (DEV),
    .REG_NUM  (10'd3),
    .PWR_DLY  (16'd16),
    .GAP_DLY  (8'd4),
    .MAX_RETRY(2'd3)
  ) dut (
    .clk_80K   (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .sccb_start(sccb_start),
    .reg_data  (reg_data),
    .bit_over  (bit_over),
    .ack_err   (ack_err),
    .rom_idx   (rom_idx),
    .rom_data  (rom_data),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  // Empty table: must finish straight out of the power-up wait.
  sccb_cfg_ctrl #(
    .DEV_ADDR (DEV),
    .REG_NUM  (10'd0),
    .PWR_DLY  (16'd16),
    .GAP_DLY  (8'd4),
    .MAX_RETRY(2'd3)
  ) dut0 (
    .clk_80K   (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .sccb_start(s0_start),
    .reg_data  (s0_data),
    .bit_over  (sbo),
    .ack_err   (1'b0),
    .rom_idx   (s0_idx),
    .rom_data  (s0_rom),
    .cfg_done  (s0_done),
    .cfg_err   (s0_err)
  );

  ov5640_cfg_rom u_rom (
    .rom_idx_i (rom0_idx),
    .rom_data_o(rom0_data)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
    tot++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference model: walk the table by the ack/retry rules, recording every launch.
  task automatic plan(input int mode);
    int idx   = 0;
    int tries = 0;
    bit a;
    exp_t e;
    exp_q.delete();
    eng_acks.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    while (1) begin
      if (idx >= NREG) begin
        exp_done = 1'b1;
        break;
      end
      case (mode)
        0:       a = 1'b0;
        1:       a = (idx == 1 && tries == 0);
        2:       a = 1'b1;
        default: a = ($urandom_range(99, 0) < 35);
      endcase
      e.idx  = 10'(idx);
      e.data = {DEV, rom_tab[idx]};
      exp_q.push_back(e);
      eng_acks.push_back(a);
      if (!a) begin
        idx++;
        tries = 0;
      end else if (tries == MAXR) begin
        exp_err = 1'b1;
        break;
      end else begin
        tries++;
      end
    end
    exp_idx   = idx;
    exp_sends = exp_q.size();
  endtask

  task automatic apply_reset();
    cfg_start = 1'b0;
    sbo       = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    eng_acks.delete();
    first_pending = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {19'd0, sccb_start, reg_data, rom_idx, cfg_done, cfg_err}, 64'd0);
    check("reset_outs0", {19'd0, s0_start, s0_data, s0_idx, s0_done, s0_err}, 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_hold", {62'd0, sccb_start, cfg_done}, 64'd0);
  endtask

  // Raise cfg_start briefly, inject a stray bit_over during the power-up wait,
  // and check the empty-table instance finishing at the end of that wait.
  task automatic launch();
    @(posedge clk);
    #1;
    cfg_start     = 1'b1;
    start_cyc     = cyc;
    first_pending = 1'b1;
    bo_valid      = 1'b0;
    run_starts    = 0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 2) cfg_start = 1'b0;
      if (k == 5) sbo = 1'b1;
      if (k == 6) sbo = 1'b0;
      if (k == 8) check("pwr_idx_hold", {53'd0, rom_idx, sccb_start}, 64'd0);
    end
    check("rn0_not_yet", {63'd0, s0_done}, 64'd0);
    @(negedge clk);
    check("rn0_done", {50'd0, s0_done, s0_err, s0_start, s0_idx, 1'b0}, {50'd0, 3'b100, 11'd0});
  endtask

  task automatic wait_end(input int maxc);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {63'd0, cfg_done | cfg_err}, 64'd1);
  endtask

  task automatic run_case(input int mode, input bit mid_reset);
    int n;
    apply_reset();
    rom_tab[1] = 24'($urandom);
    rom_tab[2] = 24'($urandom);
    plan(mode);
    launch();
    if (mid_reset) begin
      n = 0;
      while (run_starts < 3 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("third_start", 64'(run_starts), 64'd3);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {19'd0, sccb_start, reg_data, rom_idx, cfg_done, cfg_err}, 64'd0);
      exp_q.delete();
      eng_acks.delete();
      first_pending = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      plan(0);
      launch();
    end
    wait_end(3000);
    @(negedge clk);
    check("end_flags", {62'd0, cfg_done, cfg_err}, {62'd0, exp_done, exp_err});
    check("end_idx", {54'd0, rom_idx}, 64'(exp_idx));
    repeat (80) @(negedge clk);
    check("send_count", 64'(run_starts), 64'(exp_sends));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("flags_hold", {62'd0, cfg_done, cfg_err}, {62'd0, exp_done, exp_err});
  endtask

  // Monitor: every launch must match the head of the expected queue and its timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sccb_start) begin
      run_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", {54'd0, rom_idx}, 64'h3ff);
      end else begin
        e = exp_q.pop_front();
        check("start_idx", {54'd0, rom_idx}, {54'd0, e.idx});
        check("start_data", {32'd0, reg_data}, {32'd0, e.data});
      end
      if (first_pending) begin
        check("pwr_latency", 64'(cyc), 64'(start_cyc + PWR + 2));
        first_pending = 1'b0;
      end else if (bo_valid) begin
        check("gap_latency", 64'(cyc), 64'(last_bo + GAPD + 2));
      end
    end
  end

  // Engine model: answer each launch after a delay, then drop a stray bit_over into GAP.
  initial begin : engine
    bit          a;
    bit          abort;
    int          lat;
    logic [31:0] held;
    forever begin
      @(negedge clk);
      if (rst_n && sccb_start) begin
        a     = (eng_acks.size() != 0) ? eng_acks.pop_front() : 1'b0;
        lat   = lat_fix ? 40 : int'($urandom_range(40, 3));
        held  = reg_data;
        abort = 1'b0;
        for (int i = 0; i < lat && !abort; i++) begin
          @(posedge clk);
          if (!rst_n) abort = 1'b1;
        end
        if (!abort) begin
          #1;
          eng_bo   = 1'b1;
          eng_ack  = a;
          last_bo  = cyc;
          bo_valid = 1'b1;
          check("data_stable", {32'd0, reg_data}, {32'd0, held});
          @(posedge clk);
          #1;
          eng_bo  = 1'b0;
          eng_ack = 1'b0;
          @(posedge clk);
          #1 eng_bo = 1'b1;
          @(posedge clk);
          #1 eng_bo = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rom_tab[0] = 24'h3008_82;
    rom_tab[1] = 24'h0;
    rom_tab[2] = 24'h0;
    rom_tab[3] = 24'hffffff;
    #1;
    check("rom_entry0", {40'd0, rom0_data}, {40'd0, 24'h3008_82});

    lat_fix = 1'b1;
    run_case(0, 1'b0);  // full run, all acknowledged
    run_case(1, 1'b0);  // single NACK on entry 1
    run_case(2, 1'b0);  // retries exhausted on entry 0
    run_case(0, 1'b1);  // reset during entry 2, then restart
    lat_fix = 1'b0;
    for (int r = 0; r < 4; r++) run_case(3, 1'b0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_ctrl.md
SCCB_CFG_CTRL -- requirements
Module: sccb_cfg_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DEV_ADDR, 8'h78, OV5640 SCCB write address.
  REG_NUM, 10'd250, number of table entries.
  PWR_DLY, 16'd1600, power-up wait in clk_80K cycles (20 ms).
  GAP_DLY, 8'd4, idle cycles between transactions.
  MAX_RETRY, 2'd3, retries per entry on NACK.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk_80K, in, 1, sole clock.
  rst_n, in, 1, asynchronous active-low reset.
  cfg_start, in, 1, level; configuration begins while high after reset.
  sccb_start, out, 1, one-cycle pulse launching one SCCB write.
  reg_data, out, 32, {DEV_ADDR, reg_addr[15:0], reg_val[7:0]} to the bit engine.
  bit_over, in, 1, one-cycle pulse from the engine marking transaction end.
  ack_err, in, 1, engine NACK flag, valid in the bit_over cycle.
  rom_idx, out, 10, table index to the ROM.
  rom_data, in, 24, {reg_addr, reg_val} from the ROM, combinational.
  cfg_done, out, 1, high once all entries are written.
  cfg_err, out, 1, high if an entry exhausted its retries.
REQ-003 There SHALL be one clock (clk_80K); reset SHALL be asynchronous, active-low (rst_n).

Function
REQ-004 The FSM states SHALL be IDLE, PWR_WAIT, LOAD, SEND, WAIT_ACK, GAP, DONE, ERROR.
REQ-005 IDLE -> PWR_WAIT when cfg_start=1; a 16-bit counter SHALL count to PWR_DLY-1, then go to LOAD.
REQ-006 LOAD SHALL register reg_data = {DEV_ADDR, rom_data} for the current rom_idx, then go to SEND.
REQ-007 SEND SHALL assert sccb_start for exactly one cycle, then go to WAIT_ACK; reg_data SHALL stay stable from LOAD until bit_over.
REQ-008 In WAIT_ACK, bit_over with ack_err=0 SHALL clear the retry count, increment rom_idx, then go to GAP.
REQ-009 In WAIT_ACK, bit_over with ack_err=1 SHALL increment the retry count and go to GAP with rom_idx unchanged (re-send); if the count already equals MAX_RETRY, go to ERROR instead.
REQ-010 GAP SHALL wait GAP_DLY cycles, then go to LOAD if rom_idx < REG_NUM, else go to DONE.
REQ-011 DONE SHALL hold cfg_done=1 and ERROR SHALL hold cfg_err=1; both are terminal until reset.
REQ-012 cfg_start deasserting after leaving IDLE SHALL be ignored.
REQ-013 bit_over outside WAIT_ACK SHALL be ignored.
REQ-014 rom_idx SHALL never exceed REG_NUM; with REG_NUM=0 the FSM SHALL go PWR_WAIT -> DONE.
REQ-015 End-to-end latency SHALL be: sccb_start in the cycle after LOAD; the next LOAD GAP_DLY+1 cycles after bit_over.

Reset
REQ-016 On rst_n=0 at any time, including mid-transaction, the block SHALL enter IDLE with these values: sccb_start=0, reg_data=0, rom_idx=0, cfg_done=0, cfg_err=0, all counters 0.
REQ-017 After reset the block SHALL restart from PWR_WAIT; resuming a partial sequence is not supported.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, the DEV_ADDR default and the reg_data field widths (8/16/8).
REQ-019 The register table SHALL be a separate sub-module, ov5640_cfg_rom: combinational index -> 24-bit case table; the controller SHALL contain no table contents.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  Power-up: cfg_start=1 with PWR_DLY=16 -> first sccb_start on cycle 18 after cfg_start, with reg_data=32'h78_3008_82 when ROM entry 0 = 24'h3008_82.
  Full run: REG_NUM=3 with an engine model returning bit_over 40 cycles after each start -> exactly 3 sccb_start pulses with indices 0,1,2, then cfg_done=1 and cfg_err=0.
  Single NACK: ack_err=1 on entry 1 once -> entry 1 sent twice with identical reg_data, then entry 2, then cfg_done=1.
  Retry exhaustion: ack_err always 1 with MAX_RETRY=3 -> 4 sends of entry 0, then cfg_err=1, no further sccb_start, cfg_done=0.
  Mid-transaction reset: rst_n pulsed low during WAIT_ACK of entry 2 -> all outputs 0 immediately (asynchronously); after release and cfg_start, sequence restarts at rom_idx=0.
  Spurious bit_over: a pulse injected during GAP or PWR_WAIT -> no change to state or rom_idx.
